mips_mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the 2-bit `aluop` consumed by the ALU control decoder, plus all datapath enables and muxes. It stalls on a memory ready handshake.

---
 rtl/mips_mc_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional MIPS_CTRL_PERF_CNT_EN adds instr_retired and stall_cycles counters.
module mips_mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  aluop,
    output logic [1:0]  pc_source,
`ifdef MIPS_CTRL_PERF_CNT_EN
    output logic [31:0] instr_retired,
    output logic [31:0] stall_cycles,
`endif
    output logic        illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BEQ       = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    state_t state;
    state_t state_next;

    // The branch decision is made in the datapath from pc_write_cond and zero.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                aluop     = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                aluop     = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                aluop      = 2'b01;
                // Opcode is held by the IR; anything other than lw/sw cannot reach here.
                if (opcode == OP_LW)      state_next = S_MEM_RD;
                else if (opcode == OP_SW) state_next = S_MEM_WR;
                else                      state_next = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                aluop      = 2'b00;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                aluop         = 2'b10;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                aluop      = 2'b11;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic retire_evt;
    logic stall_evt;

    // A FETCH->FETCH hold is a stall, not a retirement; the IDLE->FETCH start is neither.
    assign retire_evt = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);
    assign stall_evt  = !mem_ready &&
                        ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired <= 32'd0;
            stall_cycles  <= 32'd0;
        end else begin
            if (retire_evt) instr_retired <= instr_retired + 32'd1;
            if (stall_evt)  stall_cycles  <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl; counter checks are active when
// MIPS_CTRL_PERF_CNT_EN is defined.
module tb_mips_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, i_or_d;
    logic        mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, aluop, pc_source;
    logic        illegal_op;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] instr_retired;
    logic [31:0] stall_cycles;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    mips_mc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluop         (aluop),
        .pc_source     (pc_source),
`ifdef MIPS_CTRL_PERF_CNT_EN
        .instr_retired (instr_retired),
        .stall_cycles  (stall_cycles),
`endif
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {pcw, pcwc, irw, iord, mrd, mwr, rw, rdst, m2r, asa, asb[2], aluop[2], pcs[2], ill}
    function automatic logic [16:0] mk(input logic pcw, pcwc, irw, iord, mrd, mwr, rw, rdst, m2r,
                                       input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] pcs, input logic ill);
        return {pcw, pcwc, irw, iord, mrd, mwr, rw, rdst, m2r, asa, asb, aop, pcs, ill};
    endfunction

    logic [16:0] observed;
    assign observed = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop, pc_source, illegal_op};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic [16:0] e_idle, e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_mem_addr, e_mem_rd;
    logic [16:0] e_mem_wb, e_mem_wr, e_r_exec, e_r_wb, e_beq, e_addi_exec, e_addi_wb, e_jump;

    initial begin
        e_idle       = mk(0,0,0,0,0,0,0,0,0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_fetch      = mk(1,0,1,0,1,0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 0);
        e_fetch_wait = mk(0,0,0,0,1,0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 0);
        e_decode     = mk(0,0,0,0,0,0,0,0,0, 0, 2'b11, 2'b01, 2'b00, 0);
        e_decode_ill = mk(0,0,0,0,0,0,0,0,0, 0, 2'b11, 2'b01, 2'b00, 1);
        e_mem_addr   = mk(0,0,0,0,0,0,0,0,0, 1, 2'b10, 2'b01, 2'b00, 0);
        e_mem_rd     = mk(0,0,0,1,1,0,0,0,0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mem_wb     = mk(0,0,0,0,0,0,1,0,1, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mem_wr     = mk(0,0,0,1,0,1,0,0,0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_r_exec     = mk(0,0,0,0,0,0,0,0,0, 1, 2'b00, 2'b00, 2'b00, 0);
        e_r_wb       = mk(0,0,0,0,0,0,1,1,0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_beq        = mk(0,1,0,0,0,0,0,0,0, 1, 2'b00, 2'b10, 2'b01, 0);
        e_addi_exec  = mk(0,0,0,0,0,0,0,0,0, 1, 2'b10, 2'b11, 2'b00, 0);
        e_addi_wb    = mk(0,0,0,0,0,0,1,0,0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_jump       = mk(1,0,0,0,0,0,0,0,0, 0, 2'b00, 2'b00, 2'b10, 0);
    end

    // Drive one cycle's inputs on the falling edge and settle before sampling.
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clk);
        run       = r;
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [16:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        assert_count++;
        assert (obs === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expected);
        end
    endtask

    task automatic stepCheck(input string tag, input logic [5:0] op, input logic mr,
                             input logic [16:0] expected);
        applyStimulus(1'b0, op, mr);
        checkOutput(tag, expected);
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        checkOutput("reset_idle", e_idle);
`ifdef MIPS_CTRL_PERF_CNT_EN
        checkValue("reset_retired", instr_retired, 32'd0);
        checkValue("reset_stall", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        stepCheck("idle_hold", OP_R, 1'b1, e_idle);
        applyStimulus(1'b1, OP_R, 1'b1);
        checkOutput("idle_run", e_idle);

        // R-type
        stepCheck("r_fetch", OP_R, 1'b1, e_fetch);
        stepCheck("r_decode", OP_R, 1'b1, e_decode);
        stepCheck("r_exec", OP_R, 1'b1, e_r_exec);
        stepCheck("r_wb", OP_R, 1'b1, e_r_wb);

        // lw with three memory wait cycles
        zero = 1'b1;
        stepCheck("lw_fetch", OP_LW, 1'b1, e_fetch);
        stepCheck("lw_decode", OP_LW, 1'b1, e_decode);
        stepCheck("lw_addr", OP_LW, 1'b1, e_mem_addr);
        stepCheck("lw_rd_wait1", OP_LW, 1'b0, e_mem_rd);
        stepCheck("lw_rd_wait2", OP_LW, 1'b0, e_mem_rd);
        stepCheck("lw_rd_wait3", OP_LW, 1'b0, e_mem_rd);
        stepCheck("lw_rd_done", OP_LW, 1'b1, e_mem_rd);
        stepCheck("lw_wb", OP_LW, 1'b1, e_mem_wb);

        // beq then j
        stepCheck("beq_fetch", OP_BEQ, 1'b1, e_fetch);
        stepCheck("beq_decode", OP_BEQ, 1'b1, e_decode);
        stepCheck("beq_exec", OP_BEQ, 1'b1, e_beq);
        stepCheck("j_fetch", OP_J, 1'b1, e_fetch);
        stepCheck("j_decode", OP_J, 1'b1, e_decode);
        stepCheck("j_jump", OP_J, 1'b1, e_jump);

        // addi then sw (with a fetch stall and two write waits)
        zero = 1'b0;
        stepCheck("addi_fetch", OP_ADDI, 1'b1, e_fetch);
        stepCheck("addi_decode", OP_ADDI, 1'b1, e_decode);
        stepCheck("addi_exec", OP_ADDI, 1'b1, e_addi_exec);
        stepCheck("addi_wb", OP_ADDI, 1'b1, e_addi_wb);
        stepCheck("sw_fetch_wait", OP_SW, 1'b0, e_fetch_wait);
        stepCheck("sw_fetch", OP_SW, 1'b1, e_fetch);
        stepCheck("sw_decode", OP_SW, 1'b1, e_decode);
        stepCheck("sw_addr", OP_SW, 1'b1, e_mem_addr);
        stepCheck("sw_wr_wait1", OP_SW, 1'b0, e_mem_wr);
        stepCheck("sw_wr_wait2", OP_SW, 1'b0, e_mem_wr);
        stepCheck("sw_wr_done", OP_SW, 1'b1, e_mem_wr);

        // Illegal opcode
        stepCheck("ill_fetch", OP_BAD, 1'b1, e_fetch);
        stepCheck("ill_decode", OP_BAD, 1'b1, e_decode_ill);
        stepCheck("ill_next_fetch", OP_LW, 1'b1, e_fetch);
`ifdef MIPS_CTRL_PERF_CNT_EN
        checkValue("retired_count", instr_retired, 32'd7);
        checkValue("stall_count", stall_cycles, 32'd6);
`endif

        // lw aborted by an asynchronous reset in MEM_WB
        stepCheck("lw2_decode", OP_LW, 1'b1, e_decode);
        stepCheck("lw2_addr", OP_LW, 1'b1, e_mem_addr);
        stepCheck("lw2_rd", OP_LW, 1'b1, e_mem_rd);
        stepCheck("lw2_wb", OP_LW, 1'b1, e_mem_wb);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_idle", e_idle);
        checkValue("async_reset_reg_write", {31'd0, reg_write}, 32'd0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        checkValue("async_reset_retired", instr_retired, 32'd0);
        checkValue("async_reset_stall", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        stepCheck("post_reset_idle", OP_R, 1'b1, e_idle);
        applyStimulus(1'b1, OP_J, 1'b1);
        checkOutput("post_reset_run", e_idle);
        stepCheck("post_reset_fetch", OP_J, 1'b1, e_fetch);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
